// File: rtl/stopwatch_pkg.sv
// Shared state encoding and key-action codes for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StPause  = 3'd2,
    StSetSec = 3'd3,
    StSetMin = 3'd4
  } state_e;

  // Winning key pulse of a cycle after priority resolution.
  typedef enum logic [2:0] {
    KeyNone,
    KeyRun,
    KeyMode,
    KeyInc,
    KeyClr
  } key_e;

  function automatic logic is_set(state_e s);
    return (s == StSetSec) || (s == StSetMin);
  endfunction

endpackage

// File: rtl/key_edge.sv
// Raw active-low key -> 2-flop synchronizer + previous-value flop -> 1-cycle press pulse.
module key_edge (
  input  logic fclk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic       sync1_q, sync2_q, prev_q;
  logic [2:0] arm_q;

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      arm_q   <= '0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      arm_q   <= {arm_q[1:0], 1'b1};
    end
  end

  // Suppressed until the pipeline holds real key samples, so a key held through reset release
  // does not register as a press.
  assign press = arm_q[2] & prev_q & ~sync2_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: key decode, run/pause/set sequencing, digit-chain enables.
// Optional display blink strobe is built only when STOPWATCH_BLINK_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
(
  input  logic              fclk,
  input  logic              reset,
  input  logic              tick,
  input  logic              key_run_n,
  input  logic              key_mode_n,
  input  logic              key_inc_n,
  input  logic              key_clr_n,
  input  logic              cy_sec,
  output logic              sec_en_n,
  output logic              min_en_n,
  output logic              clr_n,
  output logic [StateW-1:0] state,
  output logic              blink
);

  logic   press_run, press_mode, press_inc, press_clr;
  key_e   key_sel;
  state_e state_q, state_d;
  logic   sec_en_n_q, sec_en_n_d;
  logic   min_en_n_q, min_en_n_d;
  logic   clr_n_q, clr_n_d;
  logic   cy_q, cy_prev_q, cy_rise;

  key_edge u_key_run  (.fclk(fclk), .reset(reset), .key_n(key_run_n),  .press(press_run));
  key_edge u_key_mode (.fclk(fclk), .reset(reset), .key_n(key_mode_n), .press(press_mode));
  key_edge u_key_inc  (.fclk(fclk), .reset(reset), .key_n(key_inc_n),  .press(press_inc));
  key_edge u_key_clr  (.fclk(fclk), .reset(reset), .key_n(key_clr_n),  .press(press_clr));

  always_comb begin
    key_sel = KeyNone;
    if (press_clr)       key_sel = KeyClr;
    else if (press_run)  key_sel = KeyRun;
    else if (press_mode) key_sel = KeyMode;
    else if (press_inc)  key_sel = KeyInc;
  end

  assign cy_rise = cy_q & ~cy_prev_q;

  always_comb begin
    state_d = state_q;
    if (key_sel == KeyClr && state_q != StRun) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StPause: begin
          if (key_sel == KeyRun)       state_d = StRun;
          else if (key_sel == KeyMode) state_d = StSetSec;
        end
        StRun:    if (key_sel == KeyRun)  state_d = StPause;
        StSetSec: if (key_sel == KeyMode) state_d = StSetMin;
        StSetMin: if (key_sel == KeyMode) state_d = StPause;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Enables decode from the pre-transition state; the *_q term forbids back-to-back lows.
  always_comb begin
    sec_en_n_d = ~(((state_q == StRun) & tick) |
                   ((state_q == StSetSec) & (key_sel == KeyInc))) | ~sec_en_n_q;
    min_en_n_d = ~(((state_q == StRun) & cy_rise) |
                   ((state_q == StSetMin) & (key_sel == KeyInc))) | ~min_en_n_q;
    clr_n_d    = ~((key_sel == KeyClr) & (state_q != StRun)) | ~clr_n_q;
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      sec_en_n_q <= 1'b1;
      min_en_n_q <= 1'b1;
      clr_n_q    <= 1'b1;
      cy_q       <= 1'b0;
      cy_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_en_n_q <= sec_en_n_d;
      min_en_n_q <= min_en_n_d;
      clr_n_q    <= clr_n_d;
      cy_q       <= cy_sec;
      cy_prev_q  <= cy_q;
    end
  end

  assign state    = state_q;
  assign sec_en_n = sec_en_n_q;
  assign min_en_n = min_en_n_q;
  assign clr_n    = clr_n_q;

`ifdef STOPWATCH_BLINK_EN
  logic blink_q, blink_d;

  always_comb begin
    blink_d = 1'b0;
    if (is_set(state_d)) begin
      if (state_d != state_q) blink_d = 1'b1;
      else                    blink_d = blink_q ^ tick;
    end
  end

  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) blink_q <= 1'b0;
    else        blink_q <= blink_d;
  end

  assign blink = blink_q;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized + directed bench for stopwatch_ctrl against a history-based reference model.
module tb_stopwatch_ctrl;

  localparam int unsigned HistLen = 4096;
`ifdef STOPWATCH_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  localparam bit [3:0] MRun = 4'b0001, MMode = 4'b0010, MInc = 4'b0100, MClr = 4'b1000;
  localparam int unsigned ActNone = 0, ActRun = 1, ActMode = 2, ActInc = 3, ActClr = 4;

  logic       fclk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       key_run_n = 1'b1, key_mode_n = 1'b1, key_inc_n = 1'b1, key_clr_n = 1'b1;
  logic       cy_sec = 1'b0;
  logic       sec_en_n, min_en_n, clr_n, blink;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_sec_lo, n_min_lo, n_clr_lo;

  always #5 fclk = ~fclk;

  stopwatch_ctrl dut (
    .fclk      (fclk),
    .reset     (reset),
    .tick      (tick),
    .key_run_n (key_run_n),
    .key_mode_n(key_mode_n),
    .key_inc_n (key_inc_n),
    .key_clr_n (key_clr_n),
    .cy_sec    (cy_sec),
    .sec_en_n  (sec_en_n),
    .min_en_n  (min_en_n),
    .clr_n     (clr_n),
    .state     (state),
    .blink     (blink)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw input levels per clock edge since reset release, index = edge + 2.
  bit [3:0]    key_hist [HistLen];  // {clr, inc, mode, run}
  bit          cy_hist  [HistLen];
  int          m;
  int unsigned ms;
  bit          m_sec_n, m_min_n, m_clr_n, m_blink;

  function automatic int idx(input int e);
    return e + 2;
  endfunction

  // A press acts on the 3rd edge after the key is first seen low, i.e. high at edge m-3, low at m-2.
  function automatic bit pressed(input int k);
    return (m >= 4) && key_hist[idx(m - 3)][k] && !key_hist[idx(m - 2)][k];
  endfunction

  function automatic int unsigned next_state(input int unsigned ps, input int unsigned act);
    if (act == ActClr) return (ps == 1) ? 1 : 0;
    case (ps)
      0, 2:    return (act == ActRun) ? 1 : (act == ActMode) ? 3 : ps;
      1:       return (act == ActRun) ? 2 : 1;
      3:       return (act == ActMode) ? 4 : 3;
      4:       return (act == ActMode) ? 2 : 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m = 0;
    for (int i = 0; i < 3; i++) begin
      key_hist[i] = 4'hF;
      cy_hist[i]  = 1'b0;
    end
    ms = 0; m_sec_n = 1'b1; m_min_n = 1'b1; m_clr_n = 1'b1; m_blink = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned act, ps, ns;
    bit rise, sec_req, min_req, clr_req, ns_set;
    m++;
    if (idx(m) >= HistLen) begin
      $display("FAIL history: got edge %0d, expected below %0d", m, HistLen - 2);
      $fatal(1);
    end
    key_hist[idx(m)] = {key_clr_n, key_inc_n, key_mode_n, key_run_n};
    cy_hist[idx(m)]  = cy_sec;
    act = ActNone;
    if (pressed(3))      act = ActClr;
    else if (pressed(0)) act = ActRun;
    else if (pressed(1)) act = ActMode;
    else if (pressed(2)) act = ActInc;
    rise    = cy_hist[idx(m - 1)] && !cy_hist[idx(m - 2)];
    ps      = ms;
    ns      = next_state(ps, act);
    sec_req = (ps == 1 && tick) || (ps == 3 && act == ActInc);
    min_req = (ps == 1 && rise) || (ps == 4 && act == ActInc);
    clr_req = (act == ActClr) && (ps != 1);
    m_sec_n = !(sec_req && m_sec_n);
    m_min_n = !(min_req && m_min_n);
    m_clr_n = !(clr_req && m_clr_n);
    ns_set  = (ns == 3) || (ns == 4);
    if (BlinkEn && ns_set) m_blink = (ns != ps) ? 1'b1 : (m_blink ^ tick);
    else                   m_blink = 1'b0;
    ms = ns;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge fclk);
    @(negedge fclk);
    check("state", state, ms);
    check("sec_en_n", sec_en_n, m_sec_n);
    check("min_en_n", min_en_n, m_min_n);
    check("clr_n", clr_n, m_clr_n);
    check("blink", blink, m_blink);
    if (!sec_en_n) n_sec_lo++;
    if (!min_en_n) n_min_lo++;
    if (!clr_n)    n_clr_lo++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input bit [3:0] mask);
    {key_clr_n, key_inc_n, key_mode_n, key_run_n} = ~mask;
    idle(4);
    {key_clr_n, key_inc_n, key_mode_n, key_run_n} = 4'hF;
    idle(3);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  task automatic zero_counts();
    n_sec_lo = 0; n_min_lo = 0; n_clr_lo = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int since_tick;
    int cnt;
    model_reset();
    zero_counts();
    #12;
    check("rst_state", state, 0);
    check("rst_sec_en_n", sec_en_n, 1);
    check("rst_min_en_n", min_en_n, 1);
    check("rst_clr_n", clr_n, 1);
    check("rst_blink", blink, 0);
    @(negedge fclk);
    reset = 1'b1;
    idle(3);

    // Run press: state changes on the 3rd edge after the key falls; ticks then enable seconds.
    key_run_n = 1'b0;
    cycle(); check("run_edge1", state, 0);
    cycle(); check("run_edge2", state, 0);
    cycle(); check("run_edge3", state, 1);
    key_run_n = 1'b1;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1;
      cycle(); check("tick_sec_low", sec_en_n, 0);
      tick = 1'b0;
      cycle(); check("tick_sec_high", sec_en_n, 1);
      idle(2);
    end

    // Carry held high for 5 cycles yields a single minute enable.
    zero_counts();
    cy_sec = 1'b1;
    cycle(); check("cy_reg_edge", min_en_n, 1);
    cycle(); check("cy_min_low", min_en_n, 0);
    idle(3);
    cy_sec = 1'b0;
    idle(3);
    check("cy_min_pulses", n_min_lo, 1);

    // Set sequence from PAUSE.
    press(MRun); check("to_pause", state, 2);
    zero_counts();
    press(MMode); check("to_set_sec", state, 3);
    press(MInc);
    press(MInc);
    press(MMode); check("to_set_min", state, 4);
    press(MInc);
    press(MMode); check("set_to_pause", state, 2);
    check("set_sec_pulses", n_sec_lo, 2);
    check("set_min_pulses", n_min_lo, 1);

    // Simultaneous run+clr in PAUSE: clear has priority.
    zero_counts();
    press(MRun | MClr);
    check("runclr_state", state, 0);
    check("runclr_clr_pulses", n_clr_lo, 1);
    press(MRun); press(MRun); check("pause_again", state, 2);
    zero_counts();
    press(MClr);
    check("clr_state", state, 0);
    check("clr_pulses", n_clr_lo, 1);
    press(MRun);
    zero_counts();
    press(MClr);
    check("clr_in_run_state", state, 1);
    check("clr_in_run_pulses", n_clr_lo, 0);

    // Asynchronous reset in the middle of a sec_en_n low pulse.
    tick = 1'b1;
    model_edge();
    @(posedge fclk);
    #2;
    check("pre_rst_sec_low", sec_en_n, m_sec_n);
    reset = 1'b0;
    #1;
    check("mid_rst_sec_en_n", sec_en_n, 1);
    check("mid_rst_state", state, 0);
    tick = 1'b0;
    key_mode_n = 1'b0;  // held through reset release: must not act as a press
    @(negedge fclk);
    @(negedge fclk);
    reset = 1'b1;
    model_reset();
    idle(6);
    check("held_key_state", state, 0);
    key_mode_n = 1'b1;
    idle(3);

    // Blink in SET_SEC over two ticks.
    press(MMode);
    check("blink_state", state, 3);
    check("blink_entry", blink, BlinkEn);
    pulse_tick();
    check("blink_tick1", blink, 0);
    pulse_tick();
    check("blink_tick2", blink, BlinkEn);
    press(MMode);
    press(MMode);
    check("blink_exit", blink, 0);

    // Randomized traffic.
    since_tick = 2;
    cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(7) == 0)  key_run_n  = ~key_run_n;
      if ($urandom_range(7) == 0)  key_mode_n = ~key_mode_n;
      if ($urandom_range(5) == 0)  key_inc_n  = ~key_inc_n;
      if ($urandom_range(29) == 0) key_clr_n  = ~key_clr_n;
      if ($urandom_range(9) == 0)  cy_sec     = ~cy_sec;
      tick = (since_tick >= 2) && ($urandom_range(3) == 0);
      cycle();
      since_tick = tick ? 0 : since_tick + 1;
      if (state != 0) cnt++;
    end
    tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
